banked_ram: RTL and testbench

Parametrised, banked, synchronous single-port RAM for the SingleCycleComputer memory system. It is the successor to the single-chip RAM and generalises it in three ways: data width, depth and bank count are configurable, writes can be byte-masked, and reads are registered with a valid strobe. An optional power-on clear sequencer zeroes all contents before the first access is accepted. It sits between the SCC datapath/load-store logic and nothing else; one instance serves instruction or data memory.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_bank.sv | 46 ++++
 rtl/banked_ram.sv | 129 ++++++++++++
 tb/tb_banked_ram.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared sizing helpers and FSM state type for the banked RAM slice.
// Address split is low-order interleave: bank bits at the bottom, row bits above.
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic int bank_bits(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int row_bits(input int addr_width, input int num_banks);
    return addr_width - $clog2(num_banks);
  endfunction

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  localparam int BANK_BITS = bank_bits(4);
  localparam int ROW_BITS  = row_bits(10, 4);
  localparam int BYTES     = bytes_of(32);

endpackage

// File: rtl/mem_bank.sv
// One RAM bank: byte-masked write port, registered read; 1-cycle read, no backpressure.
// Only the read register is reset; the array itself is never reset.
module mem_bank
  import mem_pkg::*;
#(
  parameter int ROW_W      = 8,
  parameter int ROWS       = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic                    i_re,
  input  logic [ROW_W-1:0]        i_row,
  input  logic [DATA_WIDTH/8-1:0] i_byte_en,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]   o_data
);

  localparam int NBYTES = bytes_of(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [ROWS];
  logic [DATA_WIDTH-1:0] r_rd;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (i_byte_en[b]) begin
          r_mem[i_row][b*8 +: 8] <= i_data[b*8 +: 8];
        end
      end
    end
  end

  // Holds until this bank's next read, so it doubles as the top's read register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd <= '0;
    end else if (i_re) begin
      r_rd <= r_mem[i_row];
    end
  end

  assign o_data = r_rd;

endmodule

// File: rtl/banked_ram.sv
// Banked single-port RAM, 1-cycle registered read with rvalid; requests dropped while ready=0.
// MEM_CLEAR_EN adds a power-on CLEAR pass that zeroes every row before ready rises.
module banked_ram
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cs,
  input  logic                    i_we,
  input  logic                    i_oe,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  input  logic [DATA_WIDTH/8-1:0] i_byte_en,
  input  logic [DATA_WIDTH-1:0]   i_data_in,
  output logic [DATA_WIDTH-1:0]   o_data_out,
  output logic                    o_rvalid,
  output logic                    o_ready
);

  localparam int NB_BITS = bank_bits(NUM_BANKS);
  localparam int RW_BITS = row_bits(ADDR_WIDTH, NUM_BANKS);
  localparam int N_ROWS  = 1 << RW_BITS;
  localparam int N_BYTES = bytes_of(DATA_WIDTH);
  localparam int BNK_W   = (NB_BITS > 0) ? NB_BITS : 1;
  localparam int ROW_W   = (RW_BITS > 0) ? RW_BITS : 1;

  localparam logic [0:0] S_CLEAR = CLEAR;
  localparam logic [0:0] S_RUN   = RUN;

  logic [0:0]            r_state;
  logic [BNK_W-1:0]      r_sel;
  logic                  r_rvalid;
  logic [BNK_W-1:0]      w_bank;
  logic [ROW_W-1:0]      w_row;
  logic [ROW_W-1:0]      w_clear_row;
  logic                  w_clearing;
  logic                  w_acc;
  logic                  w_rd;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_bank_dout [NUM_BANKS];

  // Degenerate splits (one bank, or one row per bank) need no slicing.
  generate
    if (NB_BITS == 0) begin : g_one_bank
      assign w_bank = '0;
      assign w_row  = i_address;
    end else if (RW_BITS == 0) begin : g_one_row
      assign w_bank = i_address;
      assign w_row  = '0;
    end else begin : g_split
      assign w_bank = i_address[NB_BITS-1:0];
      assign w_row  = i_address[ADDR_WIDTH-1:NB_BITS];
    end
  endgenerate

`ifdef MEM_CLEAR_EN
  logic [ROW_W-1:0] r_clear_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_CLEAR;
      r_clear_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clear_cnt <= r_clear_cnt + 1'b1;
      if (r_clear_cnt == ROW_W'(N_ROWS - 1)) begin
        r_state <= S_RUN;
      end
    end
  end

  assign w_clearing  = (r_state == S_CLEAR);
  assign w_clear_row = r_clear_cnt;
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_RUN;
    end
  end

  assign w_clearing  = 1'b0;
  assign w_clear_row = '0;
`endif

  assign o_ready = (r_state == S_RUN) && !i_rst;
  assign w_acc   = i_cs && o_ready;
  assign w_rd    = w_acc && !i_we;
  assign w_wr    = w_acc && i_we;

  generate
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic w_hit;
      assign w_hit = (w_bank == BNK_W'(g));

      mem_bank #(
        .ROW_W      (ROW_W),
        .ROWS       (N_ROWS),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_clearing || (w_wr && w_hit)),
        .i_re      (w_rd && w_hit),
        .i_row     (w_clearing ? w_clear_row : w_row),
        .i_byte_en (w_clearing ? {N_BYTES{1'b1}} : i_byte_en),
        .i_data    (w_clearing ? {DATA_WIDTH{1'b0}} : i_data_in),
        .o_data    (w_bank_dout[g])
      );
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel    <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_sel <= w_bank;
      end
    end
  end

  assign o_rvalid   = r_rvalid;
  assign o_data_out = i_oe ? w_bank_dout[r_sel] : '0;

endmodule

// File: tb/tb_banked_ram.sv
// Self-checking bench for banked_ram against an array model of the word memory.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_banked_ram;

  localparam int NWORDS = 1024;
  localparam int ROWS   = 256;
`ifdef MEM_CLEAR_EN
  localparam int EXP_LOWS = ROWS;
`else
  localparam int EXP_LOWS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic        oe;
  logic [9:0]  addr;
  logic [3:0]  be;
  logic [31:0] din;
  logic [31:0] dout;
  logic        rvalid;
  logic        ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [NWORDS];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  banked_ram #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32),
    .NUM_BANKS  (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cs       (cs),
    .i_we       (we),
    .i_oe       (oe),
    .i_address  (addr),
    .i_byte_en  (be),
    .i_data_in  (din),
    .o_data_out (dout),
    .o_rvalid   (rvalid),
    .o_ready    (ready)
  );

  task automatic drive(input logic c, input logic w, input logic o,
                       input logic [9:0] a, input logic [3:0] b, input logic [31:0] d);
    cs = c; we = w; oe = o; addr = a; be = b; din = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic model_after_reset();
`ifdef MEM_CLEAR_EN
    for (int i = 0; i < NWORDS; i++) model[i] = 32'h0;
`endif
    last_rd = 32'h0;
  endtask

  task automatic test_reset();
    int lows;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 10'h0, 4'h0, 32'h0);
    repeat (3) step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
    rst = 1'b0;
    #1;
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      if (ready === 1'b1) break;
      lows++;
      step();
    end
    checks++; if (lows !== EXP_LOWS) begin errors++; $display("FAIL clear_len got %0d want %0d", lows, EXP_LOWS); end
    model_after_reset();
`ifdef MEM_CLEAR_EN
    begin
      logic [9:0] probe [3];
      probe[0] = 10'h000; probe[1] = 10'h0FF; probe[2] = 10'h3FF;
      for (int k = 0; k < 3; k++) begin
        drive(1'b1, 1'b0, 1'b1, probe[k], 4'h0, 32'h0);
        step();
        checks++; if (rvalid !== 1'b1 || dout !== 32'h0) begin
          errors++; $display("FAIL clear_read addr %h got rv=%b %h want rv=1 0", probe[k], rvalid, dout);
        end
      end
      drive(1'b0, 1'b0, 1'b1, 10'h0, 4'h0, 32'h0);
    end
`endif
  endtask

  task automatic test_byte_mask();
    drive(1'b1, 1'b1, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF);
    step();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b want 0", rvalid); end
    model[5] = merge(model[5], 32'hDEADBEEF, 4'hF);
    drive(1'b1, 1'b1, 1'b1, 10'h005, 4'h5, 32'h11223344);
    step();
    model[5] = merge(model[5], 32'h11223344, 4'h5);
    drive(1'b1, 1'b0, 1'b1, 10'h005, 4'h0, 32'h0);
    step();
    last_rd = model[5];
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL mask_rvalid got %b want 1", rvalid); end
    checks++; if (dout !== 32'hDE22BE44) begin errors++; $display("FAIL mask_data got %h want DE22BE44", dout); end
    drive(1'b0, 1'b0, 1'b1, 10'h0, 4'h0, 32'h0);
    step();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got %b want 0", rvalid); end
    checks++; if (dout !== 32'hDE22BE44) begin errors++; $display("FAIL read_hold got %h want DE22BE44", dout); end
  endtask

  task automatic test_oe();
    drive(1'b1, 1'b0, 1'b0, 10'h005, 4'h0, 32'h0);
    step();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL oe_rvalid got %b want 1", rvalid); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL oe_gated got %h want 0", dout); end
    drive(1'b0, 1'b0, 1'b1, 10'h0, 4'h0, 32'h0);
    step();
    checks++; if (dout !== 32'hDE22BE44) begin errors++; $display("FAIL oe_open got %h want DE22BE44", dout); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b1, 10'(k), 4'hF, k * 32'h01010101);
      step();
      model[k] = k * 32'h01010101;
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 1'b1, 10'(k), 4'h0, 32'h0);
      step();
      last_rd = model[k];
      checks++; if (rvalid !== 1'b1 || dout !== k * 32'h01010101) begin
        errors++; $display("FAIL b2b_read %0d got rv=%b %h want rv=1 %h", k, rvalid, dout, k * 32'h01010101);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 10'h0, 4'h0, 32'h0);
    step();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", rvalid); end
  endtask

  task automatic test_random();
    for (int a = 0; a < NWORDS; a++) begin
      logic [31:0] d;
      d = $urandom;
      drive(1'b1, 1'b1, 1'b1, 10'(a), 4'hF, d);
      step();
      model[a] = d;
    end
    for (int n = 0; n < 500; n++) begin
      logic c, w, o, exp_rv;
      logic [9:0] a;
      logic [3:0] b;
      logic [31:0] d, exp_d;
      c = ($urandom_range(0, 9) < 8);
      w = $urandom_range(0, 1);
      o = ($urandom_range(0, 3) != 0);
      a = 10'($urandom_range(0, NWORDS - 1));
      b = 4'($urandom);
      d = $urandom;
      drive(c, w, o, a, b, d);
      step();
      exp_rv = c && !w;
      if (c && w) model[a] = merge(model[a], d, b);
      if (exp_rv) last_rd = model[a];
      exp_d = o ? last_rd : 32'h0;
      checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL rand_rvalid op %0d got %b want %b", n, rvalid, exp_rv); end
      checks++; if (dout !== exp_d) begin errors++; $display("FAIL rand_data op %0d got %h want %h", n, dout, exp_d); end
    end
    drive(1'b0, 1'b0, 1'b1, 10'h0, 4'h0, 32'h0);
  endtask

  task automatic test_dropped();
    logic seen_rv;
    drive(1'b1, 1'b1, 1'b1, 10'h010, 4'hF, 32'h12345678);
    step();
    model[16] = 32'h12345678;
    drive(1'b1, 1'b1, 1'b1, 10'h010, 4'hF, 32'hFFFFFFFF);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    seen_rv = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (rvalid === 1'b1) seen_rv = 1'b1;
      if (ready === 1'b1) break;
      step();
    end
    drive(1'b0, 1'b0, 1'b1, 10'h0, 4'h0, 32'h0);
    model_after_reset();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL drop_ready_timeout got %b want 1", ready); end
    checks++; if (seen_rv !== 1'b0) begin errors++; $display("FAIL drop_rvalid got %b want 0", seen_rv); end
    step();
    drive(1'b1, 1'b0, 1'b1, 10'h010, 4'h0, 32'h0);
    step();
    last_rd = model[16];
    checks++; if (rvalid !== 1'b1 || dout !== model[16]) begin
      errors++; $display("FAIL drop_read got rv=%b %h want rv=1 %h", rvalid, dout, model[16]);
    end
    drive(1'b0, 1'b0, 1'b1, 10'h0, 4'h0, 32'h0);
  endtask

  task automatic test_reset_cancel();
    int lows;
    drive(1'b1, 1'b0, 1'b1, 10'h005, 4'h0, 32'h0);
    step();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL cancel_pre got %b want 1", rvalid); end
    rst = 1'b1;
    step();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL cancel_rvalid got %b want 0", rvalid); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL cancel_dout got %h want 0", dout); end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 10'h0, 4'h0, 32'h0);
    #1;
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      if (ready === 1'b1) break;
      lows++;
      step();
    end
    checks++; if (lows !== EXP_LOWS) begin errors++; $display("FAIL cancel_recover got %0d want %0d", lows, EXP_LOWS); end
    model_after_reset();
  endtask

`ifdef MEM_CLEAR_EN
  task automatic test_reset_mid_clear();
    int lows;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b1, 10'(k * 100), 4'hF, 32'hA5A5A5A5);
      step();
    end
    drive(1'b0, 1'b0, 1'b1, 10'h0, 4'h0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (100) step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midclear_busy got %b want 0", ready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      if (ready === 1'b1) break;
      lows++;
      step();
    end
    checks++; if (lows !== ROWS) begin errors++; $display("FAIL midclear_len got %0d want %0d", lows, ROWS); end
    model_after_reset();
    for (int a = 0; a < NWORDS; a++) begin
      drive(1'b1, 1'b0, 1'b1, 10'(a), 4'h0, 32'h0);
      step();
      checks++; if (rvalid !== 1'b1 || dout !== 32'h0) begin
        errors++; $display("FAIL midclear_zero addr %h got rv=%b %h want rv=1 0", a, rvalid, dout);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 10'h0, 4'h0, 32'h0);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 10'h0, 4'h0, 32'h0);
    for (int i = 0; i < NWORDS; i++) model[i] = 32'h0;
    last_rd = 32'h0;
    test_reset();
    test_byte_mask();
    test_oe();
    test_back_to_back();
    test_random();
    test_dropped();
    test_reset_cancel();
`ifdef MEM_CLEAR_EN
    test_reset_mid_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
